// File: rtl/traffic_pkg.sv
// Shared types for the traffic light controller: phase encoding, lamp bit
// positions within an approach's 3-bit lamp group, and a lamp-group helper.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    ALLRED = 2'b10,
    FLASH  = 2'b11
  } phase_t;

  localparam int LAMP_R = 2;
  localparam int LAMP_Y = 1;
  localparam int LAMP_G = 0;

  function automatic logic [2:0] lamp_bits(input int lamp_idx);
    logic [2:0] bits;
    bits = '0;
    bits[lamp_idx] = 1'b1;
    return bits;
  endfunction

endpackage

// File: rtl/rr_next_dir.sv
// Round-robin pick: first requesting approach after active_dir_i (wrapping,
// active_dir_i itself last). next_dir_o is only meaningful when found_o is high.
module rr_next_dir #(
  parameter int N_DIR = 4,
  parameter int DIR_W = 2
) (
  input  logic [N_DIR-1:0] req_i,
  input  logic [DIR_W-1:0] active_dir_i,
  output logic [DIR_W-1:0] next_dir_o,
  output logic             found_o
);

  logic [DIR_W-1:0] cand;

  always_comb begin
    next_dir_o = '0;
    found_o    = 1'b0;
    cand       = '0;
    for (int k = 1; k <= N_DIR; k++) begin
      cand = DIR_W'((int'(active_dir_i) + k) % N_DIR);
      if (!found_o && req_i[cand]) begin
        found_o    = 1'b1;
        next_dir_o = cand;
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_n.sv
// Registered round-robin traffic light controller for N_DIR approaches.
// Optional feature macro: TRAFFIC_FLASH_EN (adds flash input and FLASH phase).
//
// state  | meaning
// GREEN  | active_dir green, others red; leaves once other demand and timing allow
// YELLOW | active_dir yellow for T_YELLOW ticks
// ALLRED | every approach red for T_ALLRED ticks, then grant next approach
// FLASH  | all approaches flash yellow on tick (TRAFFIC_FLASH_EN only)
module traffic_ctrl_n
  import traffic_pkg::*;
#(
  parameter int N_DIR       = 4,
  parameter int CNT_W       = 8,
  parameter int T_GREEN_MIN = 5,
  parameter int T_GREEN_MAX = 20,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 1,
  localparam int DIR_W      = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
`ifdef TRAFFIC_FLASH_EN
  input  logic               flash,
`endif
  input  logic [N_DIR-1:0]   sensor,
  output logic [3*N_DIR-1:0] lights,
  output logic [DIR_W-1:0]   active_dir,
  output logic [1:0]         phase,
  output logic [N_DIR-1:0]   req
);

  localparam logic [CNT_W-1:0] TG_MIN = CNT_W'(T_GREEN_MIN);
  localparam logic [CNT_W-1:0] TG_MAX = CNT_W'(T_GREEN_MAX);
  localparam logic [CNT_W-1:0] TY     = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] TAR    = CNT_W'(T_ALLRED);
  localparam logic [N_DIR-1:0] ONE    = N_DIR'(1);
  localparam logic [3*N_DIR-1:0] LIGHTS_RST = {{(N_DIR-1){3'b100}}, 3'b001};

  phase_t             phase_q, phase_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_DIR-1:0]   req_q, req_d;
  logic [3*N_DIR-1:0] lights_q, lights_d;
`ifdef TRAFFIC_FLASH_EN
  logic               blink_q, blink_d;
`endif

  logic [CNT_W-1:0]   cnt_inc;
  logic [N_DIR-1:0]   dir_mask;
  logic               other_req;
  logic               sensor_act;
  logic [DIR_W-1:0]   rr_dir;
  logic               rr_found;
  logic [DIR_W-1:0]   dir_inc;

  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign dir_mask   = ONE << dir_q;
  assign other_req  = |(req_q & ~dir_mask);
  assign sensor_act = |(sensor & dir_mask);
  assign dir_inc    = (int'(dir_q) == N_DIR - 1) ? '0 : dir_q + 1'b1;

  rr_next_dir #(
    .N_DIR (N_DIR),
    .DIR_W (DIR_W)
  ) u_rr (
    .req_i        (req_q),
    .active_dir_i (dir_q),
    .next_dir_o   (rr_dir),
    .found_o      (rr_found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= GREEN;
      dir_q    <= '0;
      cnt_q    <= '0;
      req_q    <= '0;
      lights_q <= LIGHTS_RST;
`ifdef TRAFFIC_FLASH_EN
      blink_q  <= 1'b0;
`endif
    end else begin
      phase_q  <= phase_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      lights_q <= lights_d;
`ifdef TRAFFIC_FLASH_EN
      blink_q  <= blink_d;
`endif
    end
  end

  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
`ifdef TRAFFIC_FLASH_EN
    blink_d = blink_q;
`endif
    if (tick) begin
      cnt_d = cnt_inc;
      case (phase_q)
        GREEN: begin
          if (other_req && (cnt_inc >= TG_MAX || (cnt_inc >= TG_MIN && !sensor_act))) begin
            phase_d = YELLOW;
            cnt_d   = '0;
          end
        end
        YELLOW: begin
          if (cnt_inc == TY) begin
            phase_d = ALLRED;
            cnt_d   = '0;
          end
        end
        ALLRED: begin
          if (cnt_inc == TAR) begin
            phase_d = GREEN;
            cnt_d   = '0;
            dir_d   = rr_found ? rr_dir : dir_inc;
          end
        end
        default: begin
`ifdef TRAFFIC_FLASH_EN
          blink_d = ~blink_q;
`endif
        end
      endcase
    end
`ifdef TRAFFIC_FLASH_EN
    // flash overrides everything; entry restarts the blink with yellows lit
    if (flash) begin
      if (phase_q != FLASH) begin
        blink_d = 1'b1;
        cnt_d   = '0;
      end
      phase_d = FLASH;
      dir_d   = dir_q;
    end else if (phase_q == FLASH) begin
      phase_d = ALLRED;
      cnt_d   = '0;
    end
`endif

    req_d = req_q | (sensor & ~((phase_q == GREEN) ? dir_mask : '0));
    if (phase_d == GREEN && phase_q != GREEN) begin
      req_d = req_d & ~(ONE << dir_d);
    end
  end

  always_comb begin
    lights_d = '0;
    for (int i = 0; i < N_DIR; i++) begin
      lights_d[3*i +: 3] = lamp_bits(LAMP_R);
`ifdef TRAFFIC_FLASH_EN
      if (phase_d == FLASH) begin
        lights_d[3*i +: 3] = blink_d ? lamp_bits(LAMP_Y) : 3'b000;
      end else
`endif
      if (dir_d == DIR_W'(i)) begin
        case (phase_d)
          GREEN:   lights_d[3*i +: 3] = lamp_bits(LAMP_G);
          YELLOW:  lights_d[3*i +: 3] = lamp_bits(LAMP_Y);
          default: lights_d[3*i +: 3] = lamp_bits(LAMP_R);
        endcase
      end
    end
  end

  assign lights     = lights_q;
  assign active_dir = dir_q;
  assign phase      = phase_q;
  assign req        = req_q;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Scoreboard bench for traffic_ctrl_n with default parameters; stimulus queues
// expected values per cycle, a monitor compares them after each clock edge.
module tb_traffic_ctrl_n;
  import traffic_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b1;
  logic [3:0]  sensor = '0;
  logic [11:0] lights;
  logic [1:0]  active_dir;
  logic [1:0]  phase;
  logic [3:0]  req;
`ifdef TRAFFIC_FLASH_EN
  logic        flash = 1'b0;
`endif

  traffic_ctrl_n dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
`ifdef TRAFFIC_FLASH_EN
    .flash      (flash),
`endif
    .sensor     (sensor),
    .lights     (lights),
    .active_dir (active_dir),
    .phase      (phase),
    .req        (req)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int F_PH  = 0;
  localparam int F_DIR = 1;
  localparam int F_LT  = 2;
  localparam int F_REQ = 3;

  typedef struct {
    int          cyc;
    int          fld;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int base = 0;
  int n_pass = 0;
  int n_total = 0;

  task automatic expect_at(input int m, input int fld, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = base + m;
    e.fld  = fld;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int m);
    while (cyc < base + m) @(negedge clk);
  endtask

  // cycle m of a test is the state seen after edge m-1; edge 0 follows reset release
  task automatic do_reset(input string nm);
    @(negedge clk);
    reset  = 1'b1;
    sensor = '0;
    tick   = 1'b1;
`ifdef TRAFFIC_FLASH_EN
    flash  = 1'b0;
`endif
    base = cyc + 1;
    expect_at(0, F_PH,  32'd0,     {nm, "_rst_phase"});
    expect_at(0, F_DIR, 32'd0,     {nm, "_rst_dir"});
    expect_at(0, F_LT,  32'h921,   {nm, "_rst_lights"});
    expect_at(0, F_REQ, 32'd0,     {nm, "_rst_req"});
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    logic [31:0] act;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_total++;
        case (e.fld)
          F_PH:    act = 32'(phase);
          F_DIR:   act = 32'(active_dir);
          F_LT:    act = 32'(lights);
          default: act = 32'(req);
        endcase
        if (e.cyc != cyc)
          $display("FAIL %s: check due at cycle %0d reached late at %0d", e.name, e.cyc, cyc);
        else if (act !== e.val)
          $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.val);
        else
          n_pass++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit hit, %0d/%0d checks passed so far", n_pass, n_total);
    $fatal(1, "simulation time limit");
  end

  initial begin : stimulus
    exp_t e;

    // idle hold
    do_reset("idle");
    expect_at(1,   F_PH,  32'd0,   "idle_ph_c1");
    expect_at(1,   F_LT,  32'h921, "idle_lt_c1");
    expect_at(50,  F_PH,  32'd0,   "idle_ph_c50");
    expect_at(50,  F_DIR, 32'd0,   "idle_dir_c50");
    expect_at(100, F_PH,  32'd0,   "idle_ph_c100");
    expect_at(100, F_DIR, 32'd0,   "idle_dir_c100");
    expect_at(100, F_LT,  32'h921, "idle_lt_c100");
    wait_to(102);

    // basic handoff 0 -> 2
    do_reset("hand");
    sensor = 4'b0100;
    expect_at(1, F_REQ, 32'h4,   "hand_req_c1");
    expect_at(4, F_PH,  32'd0,   "hand_ph_c4");
    expect_at(5, F_PH,  32'd1,   "hand_ph_c5");
    expect_at(5, F_LT,  32'h922, "hand_lt_c5");
    expect_at(7, F_PH,  32'd1,   "hand_ph_c7");
    expect_at(8, F_PH,  32'd2,   "hand_ph_c8");
    expect_at(8, F_LT,  32'h924, "hand_lt_c8");
    expect_at(9, F_PH,  32'd0,   "hand_ph_c9");
    expect_at(9, F_DIR, 32'd2,   "hand_dir_c9");
    expect_at(9, F_LT,  32'h864, "hand_lt_c9");
    expect_at(9, F_REQ, 32'h0,   "hand_req_c9");
    wait_to(1);
    sensor = 4'b0000;
    wait_to(11);

    // max green extension, then min green on approach 1
    do_reset("max");
    sensor = 4'b0011;
    expect_at(1,  F_REQ, 32'h2, "max_req_c1");
    expect_at(19, F_PH,  32'd0, "max_ph_c19");
    expect_at(20, F_PH,  32'd1, "max_ph_c20");
    expect_at(24, F_DIR, 32'd1, "max_dir_c24");
    expect_at(24, F_REQ, 32'h1, "max_req_c24");
    expect_at(28, F_PH,  32'd0, "max_ph_c28");
    expect_at(29, F_PH,  32'd1, "max_ph_c29");
    wait_to(1);
    sensor = 4'b0001;
    wait_to(30);
    sensor = 4'b0000;
    wait_to(31);

    // round-robin wrap from approach 3
    do_reset("rr");
    sensor = 4'b1000;
    expect_at(9,  F_DIR, 32'd3, "rr_dir_c9");
    expect_at(9,  F_PH,  32'd0, "rr_ph_c9");
    expect_at(10, F_REQ, 32'h3, "rr_req_c10");
    expect_at(14, F_PH,  32'd1, "rr_ph_c14");
    expect_at(17, F_PH,  32'd2, "rr_ph_c17");
    expect_at(18, F_DIR, 32'd0, "rr_dir_c18");
    expect_at(18, F_REQ, 32'h2, "rr_req_c18");
    expect_at(27, F_DIR, 32'd1, "rr_dir_c27");
    expect_at(27, F_REQ, 32'h0, "rr_req_c27");
    expect_at(40, F_PH,  32'd0, "rr_ph_c40");
    expect_at(40, F_DIR, 32'd1, "rr_dir_c40");
    wait_to(1);
    sensor = 4'b0000;
    wait_to(9);
    sensor = 4'b1011;
    wait_to(10);
    sensor = 4'b0000;
    wait_to(41);

    // tick gating during yellow
    do_reset("tick");
    sensor = 4'b0010;
    expect_at(5,  F_PH, 32'd1,   "tick_ph_c5");
    expect_at(30, F_PH, 32'd1,   "tick_ph_c30");
    expect_at(30, F_LT, 32'h922, "tick_lt_c30");
    expect_at(56, F_PH, 32'd1,   "tick_ph_c56");
    expect_at(57, F_PH, 32'd1,   "tick_ph_c57");
    expect_at(58, F_PH, 32'd2,   "tick_ph_c58");
    wait_to(1);
    sensor = 4'b0000;
    wait_to(6);
    tick = 1'b0;
    wait_to(56);
    tick = 1'b1;
    wait_to(59);

    // reset mid-yellow on approach 2
    do_reset("mid");
    sensor = 4'b0100;
    expect_at(9,  F_DIR, 32'd2,   "mid_dir_c9");
    expect_at(14, F_PH,  32'd1,   "mid_ph_c14");
    expect_at(15, F_PH,  32'd1,   "mid_ph_c15");
    expect_at(15, F_DIR, 32'd2,   "mid_dir_c15");
    expect_at(16, F_PH,  32'd0,   "mid_ph_c16");
    expect_at(16, F_DIR, 32'd0,   "mid_dir_c16");
    expect_at(16, F_REQ, 32'h0,   "mid_req_c16");
    expect_at(16, F_LT,  32'h921, "mid_lt_c16");
    wait_to(1);
    sensor = 4'b0000;
    wait_to(9);
    sensor = 4'b0010;
    wait_to(10);
    sensor = 4'b0000;
    wait_to(15);
    reset  = 1'b1;
    sensor = 4'b1000;
    wait_to(16);
    reset  = 1'b0;
    sensor = 4'b0000;
    wait_to(17);

`ifdef TRAFFIC_FLASH_EN
    // flash entry, toggling, release through ALLRED
    do_reset("fl");
    flash = 1'b1;
    expect_at(1, F_PH,  32'd3,   "fl_ph_c1");
    expect_at(1, F_LT,  32'h492, "fl_lt_c1");
    expect_at(2, F_LT,  32'h000, "fl_lt_c2");
    expect_at(2, F_REQ, 32'h4,   "fl_req_c2");
    expect_at(3, F_LT,  32'h492, "fl_lt_c3");
    expect_at(4, F_PH,  32'd2,   "fl_ph_c4");
    expect_at(4, F_DIR, 32'd0,   "fl_dir_c4");
    expect_at(4, F_LT,  32'h924, "fl_lt_c4");
    expect_at(5, F_PH,  32'd0,   "fl_ph_c5");
    expect_at(5, F_DIR, 32'd2,   "fl_dir_c5");
    expect_at(5, F_LT,  32'h864, "fl_lt_c5");
    wait_to(1);
    sensor = 4'b0100;
    wait_to(2);
    sensor = 4'b0000;
    wait_to(3);
    flash = 1'b0;
    wait_to(7);
`endif

    repeat (4) @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_total++;
      $display("FAIL %s: check for cycle %0d never evaluated (now %0d)", e.name, e.cyc, cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
